avalon_rd_resp_buffer: RTL

// - Sits between the slave side of the Avalon-MM-to-NoC shim and the DDR3 Avalon slave.
// - The DDR3 controller ignores backpressure on readdata, so this block throttles read issue with credits.
// - Every read response is buffered in a FIFO until the NoC accepts it. Writes pass through.

---
 rtl/avalon_rd_resp_buffer_if.sv | 28 ++
 rtl/avalon_rd_resp_buffer.sv | 76 +++++++
 2 files changed

// File: rtl/avalon_rd_resp_buffer_if.sv
// Avalon-MM bus bundle used on both sides of the read-response buffer.
// The slave modport faces the shim and the master modport faces the DDR3 controller.
interface avalon_rd_resp_buffer_if #(
  parameter int unsigned ADDR_W = 29,
  parameter int unsigned DATA_W = 512
) ();
  localparam int unsigned BE_W = DATA_W / 8;

  logic [DATA_W-1:0] writedata;
  logic [ADDR_W-1:0] address;
  logic              write;
  logic              read;
  logic [BE_W-1:0]   byteenable;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic              readready;

  modport slave (
    input  writedata, address, write, read, byteenable, readready,
    output waitrequest, readdata, readdatavalid
  );

  modport master (
    output writedata, address, write, read, byteenable, readready,
    input  waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/avalon_rd_resp_buffer.sv
// Credit-throttled read-response buffer between the shim and a DDR3 slave that ignores backpressure.
// Writes pass straight through; read data is held in a first-word-fall-through FIFO until accepted.
module avalon_rd_resp_buffer #(
  parameter int unsigned AVL_ADDR_WIDTH    = 29,
  parameter int unsigned AVL_DATA_WIDTH    = 512,
  parameter int unsigned AVL_BYTE_EN_WIDTH = AVL_DATA_WIDTH / 8,
  parameter int unsigned DEPTH             = 16,
  parameter int unsigned CNT_WIDTH         = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  avalon_rd_resp_buffer_if.slave        s,
  avalon_rd_resp_buffer_if.master       m,
  output logic [CNT_WIDTH-1:0]          occupancy,
  output logic [CNT_WIDTH-1:0]          outstanding,
  output logic                          err_unsolicited
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned SUM_W = CNT_WIDTH + 1;

  logic [AVL_DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;

  logic credit_ok_c;
  logic issue_c;
  logic push_c;
  logic pop_c;
  logic unsolicited_c;

  // Write path and addressing are pure passthrough.
  assign m.writedata  = AVL_DATA_WIDTH'(s.writedata);
  assign m.address    = AVL_ADDR_WIDTH'(s.address);
  assign m.byteenable = AVL_BYTE_EN_WIDTH'(s.byteenable);
  assign m.write      = s.write;
  assign m.readready  = 1'b1;

  // Credits count both in-flight reads and buffered responses, so a solicited push always fits.
  assign credit_ok_c   = (SUM_W'(outstanding) + SUM_W'(occupancy)) < SUM_W'(DEPTH);
  assign m.read        = s.read & credit_ok_c;
  assign s.waitrequest = m.waitrequest | (s.read & ~credit_ok_c);

  assign issue_c       = m.read & ~m.waitrequest;
  assign push_c        = m.readdatavalid & (outstanding != '0);
  assign unsolicited_c = m.readdatavalid & (outstanding == '0);
  assign pop_c         = s.readdatavalid & s.readready;

  assign s.readdatavalid = (occupancy != '0);
  assign s.readdata      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      occupancy       <= '0;
      outstanding     <= '0;
      err_unsolicited <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);

      if (push_c && !pop_c)      occupancy <= occupancy + CNT_WIDTH'(1);
      else if (pop_c && !push_c) occupancy <= occupancy - CNT_WIDTH'(1);

      if (issue_c && !push_c)      outstanding <= outstanding + CNT_WIDTH'(1);
      else if (push_c && !issue_c) outstanding <= outstanding - CNT_WIDTH'(1);

      if (unsolicited_c) err_unsolicited <= 1'b1;
    end
  end

  // Storage carries no reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= m.readdata;
  end
endmodule
